sobel_window_ctrl: RTL and testbench

Frame sequencer for the 3x3 window generator (`matrix_3x3`) in the Sobel edge-detection path. It accepts an 8-bit pixel stream over a valid/ready handshake and starts frames on command. It feeds the window generator one pixel per accepted beat and clears its line FIFOs and counters between frames. It also flags the cycles on which the 3x3 window is complete, with the centre coordinate, so the Sobel operator stage knows which outputs are meaningful.

---
 rtl/sobel_pkg.sv | 21 ++
 rtl/pix_pos_cnt.sv | 57 +++++
 rtl/sobel_window_ctrl.sv | 162 ++++++++++++++++
 tb/tb_sobel_window_ctrl.sv | 479 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel window path.
package sobel_pkg;

    // Frame sequencer states.
    typedef enum logic [1:0] {
        StIdle,
        StClear,
        StRun,
        StDone
    } state_e;

    // Cycles the window generator is held cleared between frames.
    localparam int unsigned CLEAR_CYCLES = 2;
    // Cycles spent draining the window pipeline after the last pixel.
    localparam int unsigned DONE_CYCLES  = 2;
    // Width of row/column position counters.
    localparam int unsigned POS_W        = 16;
    // Width of the CLEAR/DONE phase counter; must hold max(CLEAR_CYCLES, DONE_CYCLES) - 1.
    localparam int unsigned PHASE_W      = 2;

endpackage

// File: rtl/pix_pos_cnt.sv
// Row/column pixel position counter with enable, synchronous clear and wrap/last flags.
module pix_pos_cnt
    import sobel_pkg::*;
#(
    parameter int unsigned COLS = 30,
    parameter int unsigned ROWS = 30
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [POS_W-1:0] row,
    output logic [POS_W-1:0] col,
    output logic             col_last,
    output logic             frame_last
);

    localparam logic [POS_W-1:0] ColMax = POS_W'(COLS - 1);
    localparam logic [POS_W-1:0] RowMax = POS_W'(ROWS - 1);

    logic [POS_W-1:0] row_q, row_d;
    logic [POS_W-1:0] col_q, col_d;

    assign col_last   = (col_q == ColMax);
    assign frame_last = col_last && (row_q == RowMax);
    assign row        = row_q;
    assign col        = col_q;

    // Next position: clear wins over advance; column wrap carries into the row.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clr) begin
            row_d = '0;
            col_d = '0;
        end else if (en) begin
            if (col_last) begin
                col_d = '0;
                row_d = (row_q == RowMax) ? '0 : row_q + POS_W'(1);
            end else begin
                col_d = col_q + POS_W'(1);
            end
        end
    end

    // Position registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

endmodule

// File: rtl/sobel_window_ctrl.sv
// Frame sequencer for the 3x3 window generator: handshake, frame FSM and window-valid pipeline.
module sobel_window_ctrl
    import sobel_pkg::*;
#(
    parameter int unsigned COL = 30,
    parameter int unsigned ROW = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        s_valid,
    input  logic        s_sof,
    input  logic [7:0]  s_data,
    output logic        s_ready,
    output logic        win_valid_in,
    output logic [7:0]  win_din,
    output logic        win_rst_n,
    output logic        out_valid,
    output logic [15:0] out_row,
    output logic [15:0] out_col,
    output logic        busy,
    output logic        frame_done,
    output logic        err_resync
);

    state_e             state_q, state_d;
    logic [PHASE_W-1:0] phase_q, phase_d;

    logic [POS_W-1:0]   row, col;
    logic               col_last, frame_last;
    logic               at_origin;
    logic               sof_err;
    logic               accept;

    logic               win_rst_n_q;
    logic               win_valid_q;
    logic [7:0]         win_din_q;
    logic               v1_q;
    logic [POS_W-1:0]   r1_q, c1_q;
    logic               ov_q;
    logic [POS_W-1:0]   orow_q, ocol_q;

    assign at_origin = (row == '0) && (col == '0);
    // A start-of-frame anywhere but the origin means the source restarted; hold that beat.
    assign sof_err   = (state_q == StRun) && s_valid && s_sof && !at_origin;
    assign accept    = s_valid && s_ready;

    pix_pos_cnt #(
        .COLS(COL),
        .ROWS(ROW)
    ) u_pos (
        .clk       (clk),
        .rst       (rst),
        .clr       (state_q == StClear),
        .en        (accept),
        .row       (row),
        .col       (col),
        .col_last  (col_last),
        .frame_last(frame_last)
    );

    // FSM state and phase registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            phase_q <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
        end
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StClear;
                    phase_d = '0;
                end
            end
            StClear: begin
                if (phase_q == PHASE_W'(CLEAR_CYCLES - 1)) begin
                    state_d = StRun;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + PHASE_W'(1);
                end
            end
            StRun: begin
                if (sof_err) begin
                    state_d = StClear;
                    phase_d = '0;
                end else if (accept && frame_last) begin
                    state_d = StDone;
                    phase_d = '0;
                end
            end
            StDone: begin
                if (phase_q == PHASE_W'(DONE_CYCLES - 1)) begin
                    state_d = StIdle;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + PHASE_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
                phase_d = '0;
            end
        endcase
    end

    // FSM outputs; s_ready never looks at s_data.
    always_comb begin
        s_ready    = (state_q == StRun) && !sof_err;
        err_resync = sof_err;
        frame_done = (state_q == StDone) && (phase_q == PHASE_W'(DONE_CYCLES - 1));
        busy       = (state_q != StIdle);
    end

    // Window feed and 2-stage valid/centre pipeline, aligned with the window-generator update.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_rst_n_q <= 1'b0;
            win_valid_q <= 1'b0;
            win_din_q   <= '0;
            v1_q        <= 1'b0;
            r1_q        <= '0;
            c1_q        <= '0;
            ov_q        <= 1'b0;
            orow_q      <= '0;
            ocol_q      <= '0;
        end else begin
            win_rst_n_q <= (state_d != StClear);
            win_valid_q <= accept;
            if (accept) begin
                win_din_q <= s_data;
            end
            v1_q <= accept && (row >= POS_W'(2)) && (col >= POS_W'(2));
            if (accept) begin
                r1_q <= row - POS_W'(1);
                c1_q <= col - POS_W'(1);
            end
            ov_q <= v1_q;
            if (v1_q) begin
                orow_q <= r1_q;
                ocol_q <= c1_q;
            end
        end
    end

    assign win_rst_n    = win_rst_n_q;
    assign win_valid_in = win_valid_q;
    assign win_din      = win_din_q;
    assign out_valid    = ov_q;
    assign out_row      = orow_q;
    assign out_col      = ocol_q;

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Directed bench for sobel_window_ctrl: a 3x3 instance and a default 30x30 instance.
module tb_sobel_window_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Default-size instance.
    logic        start, s_valid, s_sof;
    logic [7:0]  s_data;
    logic        s_ready, win_valid_in, win_rst_n, out_valid, busy, frame_done, err_resync;
    logic [7:0]  win_din;
    logic [15:0] out_row, out_col;

    // 3x3 instance.
    logic        sm_start, sm_valid, sm_sof;
    logic [7:0]  sm_data;
    logic        sm_ready, sm_wvi, sm_wrn, sm_ov, sm_busy, sm_fd, sm_err;
    logic [7:0]  sm_wdin;
    logic [15:0] sm_orow, sm_ocol;

    int tests = 0;
    int fails = 0;

    sobel_window_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .s_valid     (s_valid),
        .s_sof       (s_sof),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .win_valid_in(win_valid_in),
        .win_din     (win_din),
        .win_rst_n   (win_rst_n),
        .out_valid   (out_valid),
        .out_row     (out_row),
        .out_col     (out_col),
        .busy        (busy),
        .frame_done  (frame_done),
        .err_resync  (err_resync)
    );

    sobel_window_ctrl #(
        .COL(3),
        .ROW(3)
    ) dut_s (
        .clk         (clk),
        .rst         (rst),
        .start       (sm_start),
        .s_valid     (sm_valid),
        .s_sof       (sm_sof),
        .s_data      (sm_data),
        .s_ready     (sm_ready),
        .win_valid_in(sm_wvi),
        .win_din     (sm_wdin),
        .win_rst_n   (sm_wrn),
        .out_valid   (sm_ov),
        .out_row     (sm_orow),
        .out_col     (sm_ocol),
        .busy        (sm_busy),
        .frame_done  (sm_fd),
        .err_resync  (sm_err)
    );

    // Observation log of the default-size instance.
    logic [7:0]  din_q[$];
    logic [15:0] ov_r_q[$];
    logic [15:0] ov_c_q[$];
    int fd_cnt   = 0;
    int fdov_cnt = 0;
    int wrl_cnt  = 0;
    int err_cnt  = 0;

    always @(negedge clk) begin
        if (win_valid_in) din_q.push_back(win_din);
        if (out_valid) begin
            ov_r_q.push_back(out_row);
            ov_c_q.push_back(out_col);
        end
        if (frame_done) fd_cnt <= fd_cnt + 1;
        if (frame_done && out_valid) fdov_cnt <= fdov_cnt + 1;
        if (!win_rst_n) wrl_cnt <= wrl_cnt + 1;
        if (err_resync) err_cnt <= err_cnt + 1;
    end

    function automatic logic [7:0] pix_val(input int idx);
        return 8'((idx * 7 + 3) & 255);
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one beat to the 30x30 instance and hold it until accepted.
    task automatic send_pix(input logic [7:0] d, input logic sof);
        bit got = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_sof   = sof;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (s_ready) got = 1;
        end
        if (got) begin
            @(posedge clk);
            #1;
        end else begin
            tests++;
            fails++;
            $display("FAIL send_timeout: s_ready=%0b required 1", s_ready);
        end
        s_valid = 1'b0;
        s_sof   = 1'b0;
    endtask

    task automatic sm_send(input logic [7:0] d, input logic sof);
        bit got = 0;
        sm_valid = 1'b1;
        sm_data  = d;
        sm_sof   = sof;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (sm_ready) got = 1;
        end
        if (got) begin
            @(posedge clk);
            #1;
        end else begin
            tests++;
            fails++;
            $display("FAIL sm_send_timeout: s_ready=%0b required 1", sm_ready);
        end
        sm_valid = 1'b0;
        sm_sof   = 1'b0;
    endtask

    task automatic pulse_start;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Pixels first..last of a frame, optionally with an idle cycle after each beat.
    task automatic send_range(input int first, input int last, input bit gap);
        for (int i = first; i <= last; i++) begin
            send_pix(pix_val(i), i == 0);
            if (gap) idle(1);
        end
    endtask

    task automatic wait_fd(input int base);
        int n = 0;
        while (fd_cnt <= base && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        tests++;
        if (fd_cnt <= base) begin
            fails++;
            $display("FAIL frame_done_timeout: frame_done count=%0d required >%0d", fd_cnt, base);
        end
        idle(3);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({s_ready, win_valid_in, out_valid, busy, frame_done, err_resync, win_rst_n} !== 7'b0) begin
            fails++;
            $display("FAIL reset_flags: rdy/wv/ov/busy/fd/err/wrn=%b required 0000000",
                     {s_ready, win_valid_in, out_valid, busy, frame_done, err_resync, win_rst_n});
        end
        tests++;
        if ({win_din, out_row, out_col} !== 40'd0) begin
            fails++;
            $display("FAIL reset_data: din=%0d row=%0d col=%0d required 0", win_din, out_row,
                     out_col);
        end
        tests++;
        if ({sm_ready, sm_wvi, sm_ov, sm_busy, sm_fd, sm_err, sm_wrn} !== 7'b0) begin
            fails++;
            $display("FAIL reset_small_flags: got %b required 0000000",
                     {sm_ready, sm_wvi, sm_ov, sm_busy, sm_fd, sm_err, sm_wrn});
        end
        @(posedge clk);
        #1 rst = 1'b0;
        idle(2);
        tests++;
        if (win_rst_n !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL idle_after_reset: win_rst_n=%b busy=%b required 1 0", win_rst_n, busy);
        end
    endtask

    task automatic test_small_frame;
        int acc = 0, t_last = -100, t_ov = -1, t_fd = -1;
        int n_ov = 0, n_wrl = 0, n_wv = 0, din_err = 0;
        logic [15:0] r = '0, c = '0;
        @(posedge clk);
        #1 sm_start = 1'b1;
        @(posedge clk);
        #1 sm_start = 1'b0;
        sm_valid = 1'b1;
        sm_sof   = 1'b1;
        sm_data  = pix_val(0);
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (!sm_wrn) n_wrl++;
            if (sm_wvi) begin
                if (sm_wdin !== pix_val(n_wv)) din_err++;
                n_wv++;
            end
            if (sm_ov) begin
                n_ov++;
                t_ov = t;
                r = sm_orow;
                c = sm_ocol;
            end
            if (sm_fd) t_fd = t;
            if (sm_valid && sm_ready) begin
                acc++;
                if (acc == 9) t_last = t;
            end
            @(posedge clk);
            #1;
            if (acc >= 9) begin
                sm_valid = 1'b0;
                sm_sof   = 1'b0;
            end else begin
                sm_data = pix_val(acc);
                sm_sof  = (acc == 0);
            end
        end
        tests++;
        if (n_wrl != 2) begin
            fails++;
            $display("FAIL small_clear_len: win_rst_n low %0d cycles required 2", n_wrl);
        end
        tests++;
        if (n_ov != 1) begin
            fails++;
            $display("FAIL small_ov_count: %0d pulses required 1", n_ov);
        end
        tests++;
        if (r !== 16'd1 || c !== 16'd1) begin
            fails++;
            $display("FAIL small_ov_coord: (%0d,%0d) required (1,1)", r, c);
        end
        tests++;
        if (t_ov != t_last + 2) begin
            fails++;
            $display("FAIL small_ov_latency: cycle %0d required %0d", t_ov, t_last + 2);
        end
        tests++;
        if (t_fd != t_last + 2) begin
            fails++;
            $display("FAIL small_fd_latency: cycle %0d required %0d", t_fd, t_last + 2);
        end
        tests++;
        if (n_wv != 9 || din_err != 0) begin
            fails++;
            $display("FAIL small_din: %0d beats %0d bad required 9 beats 0 bad", n_wv, din_err);
        end
    endtask

    task automatic test_start_ignored;
        @(posedge clk);
        #1 sm_start = 1'b1;
        @(posedge clk);
        #1 sm_start = 1'b0;
        for (int i = 0; i < 4; i++) sm_send(pix_val(i), i == 0);
        sm_start = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1 sm_start = 1'b0;
        @(negedge clk);
        tests++;
        if (sm_ready !== 1'b1 || sm_wrn !== 1'b1) begin
            fails++;
            $display("FAIL start_in_run: s_ready=%b win_rst_n=%b required 1 1", sm_ready, sm_wrn);
        end
        @(posedge clk);
        #1;
        for (int i = 4; i < 9; i++) sm_send(pix_val(i), 1'b0);
        // Now in the first DONE cycle.
        sm_start = 1'b1;
        @(negedge clk);
        tests++;
        if (sm_busy !== 1'b1 || sm_fd !== 1'b0) begin
            fails++;
            $display("FAIL done_first: busy=%b frame_done=%b required 1 0", sm_busy, sm_fd);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        tests++;
        if (sm_fd !== 1'b1) begin
            fails++;
            $display("FAIL done_pulse: frame_done=%b required 1", sm_fd);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        tests++;
        if (sm_busy !== 1'b0) begin
            fails++;
            $display("FAIL start_in_fd_cycle: busy=%b required 0", sm_busy);
        end
        @(posedge clk);
        #1 sm_start = 1'b0;
        @(negedge clk);
        tests++;
        if (sm_busy !== 1'b1 || sm_wrn !== 1'b0) begin
            fails++;
            $display("FAIL start_after_fd: busy=%b win_rst_n=%b required 1 0", sm_busy, sm_wrn);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 9; i++) sm_send(pix_val(i), i == 0);
        idle(4);
        tests++;
        if (sm_busy !== 1'b0) begin
            fails++;
            $display("FAIL second_frame_end: busy=%b required 0", sm_busy);
        end
    endtask

    task automatic check_frame(input string tag, input int b_ov, input int b_din,
                               input logic [7:0] first_pix);
        int bad = 0;
        logic [7:0] exp;
        tests++;
        if (ov_r_q.size() - b_ov != 784) begin
            fails++;
            $display("FAIL %s_ov_count: %0d pulses required 784", tag, ov_r_q.size() - b_ov);
        end
        tests++;
        if (ov_r_q.size() <= b_ov || ov_r_q[b_ov] !== 16'd1 || ov_c_q[b_ov] !== 16'd1) begin
            fails++;
            $display("FAIL %s_ov_first: first window not (1,1)", tag);
        end
        tests++;
        if (ov_r_q.size() == 0 || ov_r_q[$] !== 16'd28 || ov_c_q[$] !== 16'd28) begin
            fails++;
            $display("FAIL %s_ov_last: last window not (28,28)", tag);
        end
        tests++;
        if (din_q.size() - b_din != 900) begin
            fails++;
            $display("FAIL %s_din_count: %0d beats required 900", tag, din_q.size() - b_din);
        end
        for (int i = 0; i < 900; i++) begin
            exp = (i == 0) ? first_pix : pix_val(i);
            if (b_din + i < din_q.size() && din_q[b_din + i] !== exp) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL %s_din_data: %0d wrong beats required 0", tag, bad);
        end
    endtask

    task automatic test_full_frame;
        int b_ov, b_din, b_fd, b_fdov;
        idle(3);
        b_ov   = ov_r_q.size();
        b_din  = din_q.size();
        b_fd   = fd_cnt;
        b_fdov = fdov_cnt;
        pulse_start();
        send_range(0, 899, 1'b1);
        wait_fd(b_fd);
        check_frame("toggle", b_ov, b_din, pix_val(0));
        tests++;
        if (fdov_cnt - b_fdov != 1 || fd_cnt - b_fd != 1) begin
            fails++;
            $display("FAIL toggle_fd_align: fd=%0d fd_with_ov=%0d required 1 1",
                     fd_cnt - b_fd, fdov_cnt - b_fdov);
        end
    endtask

    task automatic test_resync;
        int b_ov, b_din, b_fd, b_wrl, b_err;
        pulse_start();
        send_range(0, 156, 1'b0);
        idle(3);
        b_ov  = ov_r_q.size();
        b_din = din_q.size();
        b_fd  = fd_cnt;
        b_wrl = wrl_cnt;
        b_err = err_cnt;
        s_valid = 1'b1;
        s_sof   = 1'b1;
        s_data  = 8'hA5;
        @(negedge clk);
        tests++;
        if (s_ready !== 1'b0 || err_resync !== 1'b1) begin
            fails++;
            $display("FAIL resync_flag: s_ready=%b err_resync=%b required 0 1", s_ready,
                     err_resync);
        end
        send_pix(8'hA5, 1'b1);
        tests++;
        if (wrl_cnt - b_wrl != 2) begin
            fails++;
            $display("FAIL resync_clear_len: %0d cycles required 2", wrl_cnt - b_wrl);
        end
        send_range(1, 899, 1'b0);
        wait_fd(b_fd);
        check_frame("resync", b_ov, b_din, 8'hA5);
        tests++;
        if (err_cnt - b_err != 1) begin
            fails++;
            $display("FAIL resync_err_count: %0d pulses required 1", err_cnt - b_err);
        end
    endtask

    task automatic test_reset_midframe;
        int b_ov, b_din, b_fd;
        pulse_start();
        send_range(0, 309, 1'b0);
        rst     = 1'b1;
        s_valid = 1'b1;
        s_data  = pix_val(310);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        s_valid = 1'b0;
        @(negedge clk);
        tests++;
        if ({s_ready, win_valid_in, out_valid, busy, frame_done, err_resync, win_rst_n} !== 7'b0) begin
            fails++;
            $display("FAIL midrst_flags: rdy/wv/ov/busy/fd/err/wrn=%b required 0000000",
                     {s_ready, win_valid_in, out_valid, busy, frame_done, err_resync, win_rst_n});
        end
        tests++;
        if ({win_din, out_row, out_col} !== 40'd0) begin
            fails++;
            $display("FAIL midrst_data: din=%0d row=%0d col=%0d required 0", win_din, out_row,
                     out_col);
        end
        idle(3);
        b_ov  = ov_r_q.size();
        b_din = din_q.size();
        b_fd  = fd_cnt;
        pulse_start();
        send_range(0, 899, 1'b0);
        wait_fd(b_fd);
        check_frame("after_rst", b_ov, b_din, pix_val(0));
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        s_valid  = 1'b0;
        s_sof    = 1'b0;
        s_data   = '0;
        sm_start = 1'b0;
        sm_valid = 1'b0;
        sm_sof   = 1'b0;
        sm_data  = '0;
        test_reset();
        test_small_frame();
        test_start_ignored();
        test_full_frame();
        test_resync();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
